// File: rtl/mac_tx_frame_buf.sv
// Store-and-forward MAC transmit buffer: 36-bit word FIFO feeding a GMII byte serialiser with preamble/SFD and IFG.
// Optional minimum-length padding to 60 bytes is built when MAC_TX_PAD_EN is defined.
module mac_tx_frame_buf #(
    parameter int ADDR_W    = 9,
    parameter int WA_MARGIN = 4,
    parameter int IFG_CYC   = 12
) (
    input  logic        clk_user_i,
    input  logic        reset_i,
    output logic        Tx_mac_wa,
    input  logic        Tx_mac_wr,
    input  logic [31:0] Tx_mac_data,
    input  logic [1:0]  Tx_mac_BE,
    input  logic        Tx_mac_sop,
    input  logic        Tx_mac_eop,
    output logic [7:0]  gmii_txd_o,
    output logic        gmii_tx_en_o,
    output logic        tx_overflow_o,
    output logic        tx_busy_o
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] MARGIN  = (ADDR_W + 1)'(WA_MARGIN);
    localparam logic [15:0]     IFG_END = 16'(IFG_CYC - 1);

`ifdef MAC_TX_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_IFG} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_IFG} state_t;
`endif

    logic [35:0]     mem [DEPTH];
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] frame_cnt_q, frame_cnt_d;
    logic [ADDR_W:0] used, used_next, free_next;
    logic            wa_q, wa_d, ovf_q, ovf_d;
    logic            full, wr_acc, pop;
    logic [35:0]     rd_word;
    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      bidx_q, bidx_d;
    logic [34:0]     word_q, word_d;
`ifdef MAC_TX_PAD_EN
    logic [10:0]     bcnt_q, bcnt_d;
`endif

    // Index of the final byte in a word: eop words carry 1..4 bytes per BE.
    function automatic logic [1:0] last_byte_idx(input logic eop, input logic [1:0] be);
        if (!eop) return 2'd3;
        case (be)
            2'b00:   return 2'd3;
            2'b11:   return 2'd2;
            2'b10:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        used      = wr_ptr_q - rd_ptr_q;
        full      = (used == DEPTH_W);
        wr_acc    = Tx_mac_wr && !full;
        rd_word   = mem[rd_ptr_q[ADDR_W-1:0]];
        used_next = used + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, pop};
        free_next = DEPTH_W - used_next;
        wa_d      = (free_next >= MARGIN);
        ovf_d     = ovf_q || (Tx_mac_wr && full);
        wr_ptr_d  = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
        frame_cnt_d = frame_cnt_q + {{ADDR_W{1'b0}}, wr_acc && Tx_mac_eop}
                                  - {{ADDR_W{1'b0}}, pop && rd_word[34]};
    end

    // Serialiser next state; the next word is popped on the last byte of the current one so DATA has no bubbles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        pop     = 1'b0;
`ifdef MAC_TX_PAD_EN
        bcnt_d  = bcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame_cnt_q != '0) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd6) begin
                    state_d = S_SFD;
                    pop     = 1'b1;
                    word_d  = rd_word[34:0];
                end
            end
            S_SFD: begin
                state_d = S_DATA;
                bidx_d  = '0;
`ifdef MAC_TX_PAD_EN
                bcnt_d  = '0;
`endif
            end
            S_DATA: begin
                bidx_d = bidx_q + 2'd1;
`ifdef MAC_TX_PAD_EN
                if (bcnt_q != '1) bcnt_d = bcnt_q + 11'd1;
`endif
                if (bidx_q == last_byte_idx(word_q[34], word_q[33:32])) begin
                    if (word_q[34]) begin
                        cnt_d   = '0;
                        state_d = S_IFG;
`ifdef MAC_TX_PAD_EN
                        if (bcnt_q < 11'd59) state_d = S_PAD;
`endif
                    end else begin
                        pop    = 1'b1;
                        word_d = rd_word[34:0];
                        bidx_d = '0;
                    end
                end
            end
`ifdef MAC_TX_PAD_EN
            S_PAD: begin
                bcnt_d = bcnt_q + 11'd1;
                if (bcnt_q == 11'd59) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end
            end
`endif
            S_IFG: begin
                cnt_d = cnt_q + 16'd1;
                // A waiting frame starts straight from the gap so the gap is exactly IFG_CYC.
                if (cnt_q == IFG_END) begin
                    cnt_d   = '0;
                    state_d = (frame_cnt_q != '0) ? S_PRE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gmii_tx_en_o = 1'b0;
        gmii_txd_o   = 8'h00;
        case (state_q)
            S_PRE: begin
                gmii_tx_en_o = 1'b1;
                gmii_txd_o   = 8'h55;
            end
            S_SFD: begin
                gmii_tx_en_o = 1'b1;
                gmii_txd_o   = 8'hD5;
            end
            S_DATA: begin
                gmii_tx_en_o = 1'b1;
                case (bidx_q)
                    2'd0:    gmii_txd_o = word_q[31:24];
                    2'd1:    gmii_txd_o = word_q[23:16];
                    2'd2:    gmii_txd_o = word_q[15:8];
                    default: gmii_txd_o = word_q[7:0];
                endcase
            end
`ifdef MAC_TX_PAD_EN
            S_PAD: gmii_tx_en_o = 1'b1;
`endif
            default: ;
        endcase
    end

    assign tx_busy_o     = (state_q != S_IDLE);
    assign Tx_mac_wa     = wa_q;
    assign tx_overflow_o = ovf_q;

    always_ff @(posedge clk_user_i) begin
        if (wr_acc) mem[wr_ptr_q[ADDR_W-1:0]] <= {Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Tx_mac_data};
        word_q <= word_d;
    end

    always_ff @(posedge clk_user_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            wa_q        <= 1'b1;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
`ifdef MAC_TX_PAD_EN
            bcnt_q      <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            wa_q        <= wa_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
`ifdef MAC_TX_PAD_EN
            bcnt_q      <= bcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_tx_frame_buf.sv
// Directed bench for mac_tx_frame_buf: frame-descriptor table plus back-to-back, fill/overflow and mid-frame reset sequences.
module tb_mac_tx_frame_buf;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        Tx_mac_wa;
    logic        Tx_mac_wr;
    logic [31:0] Tx_mac_data;
    logic [1:0]  Tx_mac_BE;
    logic        Tx_mac_sop;
    logic        Tx_mac_eop;
    logic [7:0]  gmii_txd_o;
    logic        gmii_tx_en_o;
    logic        tx_overflow_o;
    logic        tx_busy_o;

    always #5 clk = ~clk;

    mac_tx_frame_buf #(.ADDR_W(9), .WA_MARGIN(4), .IFG_CYC(12)) dut (
        .clk_user_i    (clk),
        .reset_i       (reset_i),
        .Tx_mac_wa     (Tx_mac_wa),
        .Tx_mac_wr     (Tx_mac_wr),
        .Tx_mac_data   (Tx_mac_data),
        .Tx_mac_BE     (Tx_mac_BE),
        .Tx_mac_sop    (Tx_mac_sop),
        .Tx_mac_eop    (Tx_mac_eop),
        .gmii_txd_o    (gmii_txd_o),
        .gmii_tx_en_o  (gmii_tx_en_o),
        .tx_overflow_o (tx_overflow_o),
        .tx_busy_o     (tx_busy_o)
    );

    typedef struct {
        int          nwords;
        logic [1:0]  be;
        logic [7:0]  seed;
        logic [31:0] last;
        int          exp_en;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t       vecs[7];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_val(input logic [7:0] seed, input int w, input int nwords,
                                             input logic [31:0] last);
        if (w == nwords - 1) return last;
        return {seed, 8'(w), 8'(w + 64), seed ^ 8'(w)};
    endfunction

    function automatic void build_exp(input int nwords, input logic [1:0] be, input logic [7:0] seed,
                                      input logic [31:0] last);
        logic [31:0] wv;
        int nb;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int w = 0; w < nwords; w++) begin
            wv = word_val(seed, w, nwords, last);
            nb = (w == nwords - 1 && be != 2'b00) ? int'(be) : 4;
            for (int b = 0; b < nb; b++) exp_q.push_back(wv[31-8*b -: 8]);
        end
`ifdef MAC_TX_PAD_EN
        while (exp_q.size() < 68) exp_q.push_back(8'h00);
`endif
    endfunction

    task automatic write_frame(input int nwords, input logic [1:0] be, input logic [7:0] seed,
                               input logic [31:0] last);
        for (int w = 0; w < nwords; w++) begin
            Tx_mac_wr   = 1'b1;
            Tx_mac_data = word_val(seed, w, nwords, last);
            Tx_mac_sop  = (w == 0);
            Tx_mac_eop  = (w == nwords - 1);
            Tx_mac_BE   = (w == nwords - 1) ? be : 2'b00;
            @(negedge clk);
        end
        Tx_mac_wr   = 1'b0;
        Tx_mac_sop  = 1'b0;
        Tx_mac_eop  = 1'b0;
        Tx_mac_BE   = 2'b00;
        Tx_mac_data = 32'h0;
    endtask

    // Collects one tx_en burst, then counts the following low cycles while the serialiser is still busy.
    task automatic capture(output int len, output int gap);
        int t;
        t   = 0;
        len = 0;
        gap = 0;
        got_q.delete();
        while (gmii_tx_en_o !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("tx_en_rise", 32'(gmii_tx_en_o), 32'd1);
        while (gmii_tx_en_o === 1'b1 && len < 5000) begin
            got_q.push_back(gmii_txd_o);
            len++;
            @(negedge clk);
        end
        while (gmii_tx_en_o === 1'b0 && tx_busy_o === 1'b1 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
    endtask

    task automatic cmp_bytes(input string name);
        int bad;
        int n;
        bad = 0;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        chk({name, "_bytes_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int len, gap, len2, gap2, t, seen;
        logic [7:0] lb;

        reset_i     = 1'b1;
        Tx_mac_wr   = 1'b0;
        Tx_mac_data = 32'h0;
        Tx_mac_BE   = 2'b00;
        Tx_mac_sop  = 1'b0;
        Tx_mac_eop  = 1'b0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        chk("rst_wa", 32'(Tx_mac_wa), 32'd1);
        chk("rst_txd", 32'(gmii_txd_o), 32'd0);
        chk("rst_tx_en", 32'(gmii_tx_en_o), 32'd0);
        chk("rst_ovf", 32'(tx_overflow_o), 32'd0);
        chk("rst_busy", 32'(tx_busy_o), 32'd0);
        @(negedge clk);

        vecs[0] = '{16, 2'b00, 8'h10, 32'h11223344, 72, 8'h44};
        vecs[1] = '{16, 2'b01, 8'h20, 32'hAABBCCDD, 69, 8'hAA};
`ifdef MAC_TX_PAD_EN
        vecs[2] = '{5,  2'b00, 8'h30, 32'h01020304, 68, 8'h00};
        vecs[5] = '{1,  2'b01, 8'h60, 32'h5A000000, 68, 8'h00};
`else
        vecs[2] = '{5,  2'b00, 8'h30, 32'h01020304, 28, 8'h04};
        vecs[5] = '{1,  2'b01, 8'h60, 32'h5A000000, 9,  8'h5A};
`endif
        vecs[3] = '{16, 2'b11, 8'h40, 32'hA1B2C3D4, 71, 8'hC3};
        vecs[4] = '{16, 2'b10, 8'h50, 32'hA1B2C3D4, 70, 8'hB2};
        vecs[6] = '{20, 2'b00, 8'h70, 32'h11223344, 88, 8'h44};

        for (int i = 0; i < 7; i++) begin
            build_exp(vecs[i].nwords, vecs[i].be, vecs[i].seed, vecs[i].last);
            write_frame(vecs[i].nwords, vecs[i].be, vecs[i].seed, vecs[i].last);
            capture(len, gap);
            lb = (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hxx;
            chk($sformatf("v%0d_en_cycles", i), 32'(len), 32'(vecs[i].exp_en));
            chk($sformatf("v%0d_last_byte", i), 32'(lb), 32'(vecs[i].exp_last));
            cmp_bytes($sformatf("v%0d", i));
            chk($sformatf("v%0d_ifg", i), 32'(gap), 32'd12);
            chk($sformatf("v%0d_idle_busy", i), 32'(tx_busy_o), 32'd0);
        end

        build_exp(16, 2'b00, 8'h31, 32'h0A0B0C0D);
        fork
            begin
                write_frame(16, 2'b00, 8'h31, 32'h0A0B0C0D);
                write_frame(16, 2'b00, 8'h31, 32'h0A0B0C0D);
            end
            begin
                capture(len, gap);
                chk("b2b_f1_en_cycles", 32'(len), 32'd72);
                cmp_bytes("b2b_f1");
                chk("b2b_gap", 32'(gap), 32'd12);
                capture(len2, gap2);
                chk("b2b_f2_en_cycles", 32'(len2), 32'd72);
                cmp_bytes("b2b_f2");
                chk("b2b_f2_ifg", 32'(gap2), 32'd12);
            end
        join
        chk("b2b_frame_cnt", 32'(dut.frame_cnt_q), 32'd0);
        chk("b2b_idle_busy", 32'(tx_busy_o), 32'd0);

        for (int w = 0; w < 512; w++) begin
            Tx_mac_wr   = 1'b1;
            Tx_mac_data = word_val(8'h77, w, 512, 32'hCAFEF00D);
            Tx_mac_sop  = (w == 0);
            Tx_mac_eop  = (w == 511);
            Tx_mac_BE   = 2'b00;
            @(negedge clk);
            if (w == 507) chk("fill_wa_free4", 32'(Tx_mac_wa), 32'd1);
            if (w == 508) chk("fill_wa_free3", 32'(Tx_mac_wa), 32'd0);
        end
        chk("fill_ovf_clear", 32'(tx_overflow_o), 32'd0);
        Tx_mac_data = 32'hDEADBEEF;
        Tx_mac_sop  = 1'b0;
        Tx_mac_eop  = 1'b0;
        @(negedge clk);
        Tx_mac_wr   = 1'b0;
        Tx_mac_data = 32'h0;
        chk("fill_ovf_set", 32'(tx_overflow_o), 32'd1);
        build_exp(512, 2'b00, 8'h77, 32'hCAFEF00D);
        capture(len, gap);
        chk("fill_en_cycles", 32'(len), 32'd2056);
        cmp_bytes("fill");
        chk("fill_ovf_sticky", 32'(tx_overflow_o), 32'd1);

        write_frame(16, 2'b00, 8'h55, 32'h99887766);
        t = 0;
        while (gmii_tx_en_o !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_tx_en_rise", 32'(gmii_tx_en_o), 32'd1);
        repeat (38) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("rstmid_tx_en", 32'(gmii_tx_en_o), 32'd0);
        chk("rstmid_wa", 32'(Tx_mac_wa), 32'd1);
        chk("rstmid_busy", 32'(tx_busy_o), 32'd0);
        chk("rstmid_ovf", 32'(tx_overflow_o), 32'd0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (gmii_tx_en_o === 1'b1) seen++;
        end
        chk("rstmid_quiet", 32'(seen), 32'd0);
        build_exp(5, 2'b00, 8'h66, 32'h01020304);
        write_frame(5, 2'b00, 8'h66, 32'h01020304);
        capture(len, gap);
`ifdef MAC_TX_PAD_EN
        chk("rstmid_new_en_cycles", 32'(len), 32'd68);
`else
        chk("rstmid_new_en_cycles", 32'(len), 32'd28);
`endif
        cmp_bytes("rstmid_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
